// File: rtl/uart_rx_parity.sv
// UART receiver: 1 start, 8 data (LSB first), 1 even-parity and 1 stop bit.
// Emits the received byte with a one-cycle strobe plus parity/framing error strobes.
module uart_rx_parity #(
    parameter int unsigned CLKS_PER_BIT = 32,
    parameter int unsigned ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx,
    output logic [7:0]           data,
    output logic [8:0]           frame,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitHigh
    } state_e;

    state_e                 state_q, state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [7:0]             data_q, data_d;
    logic [8:0]             frame_q, frame_d;
    logic                   dv_q, dv_d;
    logic                   pe_q, pe_d;
    logic                   fe_q, fe_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   sample;
    logic                   par_bad;

    // Mid-bit sample point: the timer is preloaded in IDLE so that the
    // start bit is sampled half a bit period after detection.
    assign sample  = (bit_cnt_q == CntLast);
    assign par_bad = (^shift_q) ^ par_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        data_d    = data_q;
        frame_d   = frame_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        fe_d      = 1'b0;

        case (state_q)
            StIdle: begin
                bit_cnt_d = '0;
                if (!rx_s_q) begin
                    state_d   = StStart;
                    bit_cnt_d = CntHalf;
                end
            end
            StStart: begin
                if (sample) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s_q ? StIdle : StData;
                end
            end
            StData: begin
                if (sample) begin
                    bit_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (sample) begin
                    bit_cnt_d = '0;
                    par_d     = rx_s_q;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (sample) begin
                    bit_cnt_d = '0;
                    data_d    = shift_q;
                    frame_d   = {par_q, shift_q};
                    if (rx_s_q) begin
                        dv_d    = ~par_bad;
                        pe_d    = par_bad;
                        state_d = StIdle;
                    end else begin
                        fe_d    = 1'b1;
                        pe_d    = par_bad;
                        state_d = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        err_cnt_d = err_cnt_q;
        if ((pe_d || fe_d) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            data_q    <= '0;
            frame_q   <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            rx_meta_q <= Rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            data_q    <= data_d;
            frame_q   <= frame_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign data       = data_q;
    assign frame      = frame_q;
    assign data_valid = dv_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign busy       = (state_q != StIdle);
    assign err_count  = err_cnt_q;

endmodule
